// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared widths, weight limits, FSM state type and row slicing helpers for the perceptron trainer.
package perceptron_pkg;
  localparam int THETA_DEFAULT = 68;
  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;
  function automatic int y_bits(input int w_bits, input int hist);
    return w_bits + $clog2(hist + 1) + 1;
  endfunction
  function automatic int w_max(input int w_bits);
    return (1 << (w_bits - 1)) - 1;
  endfunction
  function automatic int w_min(input int w_bits);
    return -(1 << (w_bits - 1));
  endfunction
  function automatic int row_lsb(input int i, input int w_bits);
    return i * w_bits;
  endfunction
endpackage

// File: rtl/perceptron_weight_sat.sv
// perceptron_weight_sat: single-weight +/-1 adder that saturates at the signed range limits.
module perceptron_weight_sat
  import perceptron_pkg::*;
#(
  parameter int W_BITS = 8
) (
  input  logic [W_BITS-1:0] w,
  input  logic              inc,
  output logic [W_BITS-1:0] q
);
  localparam logic [W_BITS-1:0] W_HI = W_BITS'(w_max(W_BITS));
  localparam logic [W_BITS-1:0] W_LO = W_BITS'(w_min(W_BITS));
  localparam logic [W_BITS-1:0] ONE = 1;
  always_comb q = inc ? (w == W_HI ? w : w + ONE) : (w == W_LO ? w : w - ONE);
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: perceptron row read-modify-write trainer; optional stat counters via PERCEPTRON_TRAINER_STATS_EN.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int HIST = 28,
  parameter int W_BITS = 8,
  parameter int THETA = THETA_DEFAULT,
  localparam int Y_BITS = y_bits(W_BITS, HIST)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [INDEX_BITS-1:0]        req_idx,
  input  logic [HIST-1:0]              req_hist,
  input  logic                         req_taken,
  input  logic [Y_BITS-1:0]            req_y,
  output logic                         mem_rd_en,
  output logic [INDEX_BITS-1:0]        mem_rd_idx,
  input  logic                         mem_rd_valid,
  input  logic [(HIST+1)*W_BITS-1:0]   mem_rd_data,
  output logic                         mem_wr_en,
  output logic [INDEX_BITS-1:0]        mem_wr_idx,
  output logic [(HIST+1)*W_BITS-1:0]   mem_wr_data,
  output logic                         done,
`ifdef PERCEPTRON_TRAINER_STATS_EN
  output logic [31:0]                  stat_updates,
  output logic [31:0]                  stat_skips,
`endif
  output logic                         done_updated
);
  localparam logic signed [Y_BITS-1:0] TH_P = Y_BITS'(THETA);
  localparam logic signed [Y_BITS-1:0] TH_N = Y_BITS'(-THETA);
  state_t state;
  logic [INDEX_BITS-1:0] idx;
  logic [HIST-1:0] hist;
  logic taken;
  logic need;
  logic signed [Y_BITS-1:0] y;
  logic [HIST:0] inc_v;
  logic [(HIST+1)*W_BITS-1:0] upd;
  // Signed window compare avoids negating the most negative y.
  always_comb begin
    y = req_y;
    need = (~y[Y_BITS-1] != req_taken) || (y <= TH_P && y >= TH_N);
    inc_v = {~(hist ^ {HIST{taken}}), taken};
  end
  assign req_ready = (state == IDLE) && !rst;
  for (genvar i = 0; i <= HIST; i++) begin : g_w
    perceptron_weight_sat #(.W_BITS(W_BITS)) u_sat (
      .w(mem_rd_data[row_lsb(i, W_BITS) +: W_BITS]),
      .inc(inc_v[i]),
      .q(upd[row_lsb(i, W_BITS) +: W_BITS])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done <= 1'b0;
      done_updated <= 1'b0;
      mem_wr_data <= '0;
      mem_wr_idx <= '0;
      mem_rd_idx <= '0;
      idx <= '0;
      hist <= '0;
      taken <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done <= 1'b0;
      done_updated <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          idx <= req_idx;
          hist <= req_hist;
          taken <= req_taken;
          if (need) begin
            state <= RD;
            mem_rd_en <= 1'b1;
            mem_rd_idx <= req_idx;
          end else done <= 1'b1;
        end
        RD: state <= WAIT;
        WAIT: if (mem_rd_valid) begin
          state <= WR;
          mem_wr_data <= upd;
          mem_wr_idx <= idx;
          mem_wr_en <= 1'b1;
          done <= 1'b1;
          done_updated <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PERCEPTRON_TRAINER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates <= '0;
      stat_skips <= '0;
    end else if (done) begin
      if (done_updated) stat_updates <= stat_updates + 32'd1;
      else stat_skips <= stat_skips + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed checks of training decisions, latency, saturation and reset abort.
module tb_perceptron_trainer;
  localparam int RW = 29 * 8;
  logic clk = 0, rst, req_valid, req_ready, req_taken;
  logic [6:0] req_idx, mem_rd_idx, mem_wr_idx;
  logic [27:0] req_hist;
  logic [13:0] req_y;
  logic mem_rd_en, mem_rd_valid, mem_wr_en, done, done_updated;
  logic [RW-1:0] mem_rd_data, mem_wr_data, row;
  logic mem_hold, inject;
  int n_chk = 0, n_fail = 0, exp_upd = 0, exp_skip = 0;
`ifdef PERCEPTRON_TRAINER_STATS_EN
  logic [31:0] stat_updates, stat_skips;
`endif

  perceptron_trainer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_hist(req_hist), .req_taken(req_taken), .req_y(req_y),
    .mem_rd_en(mem_rd_en), .mem_rd_idx(mem_rd_idx), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_idx(mem_wr_idx),
    .mem_wr_data(mem_wr_data), .done(done),
`ifdef PERCEPTRON_TRAINER_STATS_EN
    .stat_updates(stat_updates), .stat_skips(stat_skips),
`endif
    .done_updated(done_updated)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd_valid <= (mem_rd_en && !mem_hold) || inject;
    mem_rd_data <= row;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] fill(input logic [7:0] b, input logic [7:0] r);
    return {{28{r}}, b};
  endfunction

  task automatic drive(input logic [6:0] idx, input logic [27:0] h, input logic t, input int y);
    req_valid = 1;
    req_idx = idx;
    req_hist = h;
    req_taken = t;
    req_y = 14'(y);
  endtask

  task automatic do_update(input string tag, input logic [6:0] idx, input logic [27:0] h,
                           input logic t, input int y, input logic [RW-1:0] rin, input logic [RW-1:0] exp);
    row = rin;
    drive(idx, h, t, y);
    chk({tag, " ready"}, req_ready, 1);
    step();
    req_valid = 0;
    chk({tag, " rd_en T+1"}, mem_rd_en, 1);
    chk({tag, " rd_idx"}, mem_rd_idx, idx);
    chk({tag, " busy"}, req_ready, 0);
    step();
    chk({tag, " rd_en T+2"}, mem_rd_en, 0);
    chk({tag, " no early wr"}, {mem_wr_en, done}, 0);
    step();
    chk({tag, " wr_en/done T+3"}, {mem_wr_en, done, done_updated}, 3'b111);
    chk({tag, " wr_idx"}, mem_wr_idx, idx);
    chk({tag, " wr_data"}, mem_wr_data, exp);
    step();
    chk({tag, " ready T+4"}, {req_ready, mem_wr_en, done}, 3'b100);
    exp_upd++;
  endtask

  task automatic do_skip(input string tag, input logic t, input int y);
    drive(7'd9, 28'h0, t, y);
    step();
    req_valid = 0;
    chk({tag, " done T+1"}, {done, done_updated, mem_rd_en, req_ready}, 4'b1001);
    step();
    chk({tag, " done cleared"}, {done, mem_rd_en}, 0);
    exp_skip++;
  endtask

  initial begin
    logic [RW-1:0] alt;
    alt = '0;
    alt[7:0] = 8'hFF;
    for (int i = 1; i <= 28; i++) alt[i*8 +: 8] = (i % 2) ? 8'hFF : 8'h01;
    rst = 1; req_valid = 0; req_idx = 0; req_hist = 0; req_taken = 0; req_y = 0;
    mem_hold = 0; inject = 0; row = '0;
    step(); step();
    chk("reset ready low", req_ready, 0);
    chk("reset strobes", {mem_rd_en, mem_wr_en, done, done_updated}, 0);
    chk("reset wr_data", mem_wr_data, 0);
    chk("reset idx", {mem_wr_idx, mem_rd_idx}, 0);
    rst = 0;
    #1;
    chk("ready after reset", req_ready, 1);

    do_update("mispredict", 7'd5, 28'hFFFFFFF, 1, -5, fill(8'h00, 8'h00), fill(8'h01, 8'h01));
    do_skip("confident", 1, 100);
    do_update("theta68", 7'd6, 28'h0, 1, 68, fill(8'h00, 8'h00), fill(8'h01, 8'hFF));
    do_skip("theta69", 1, 69);
    do_update("theta-68", 7'd7, 28'hFFFFFFF, 0, -68, fill(8'h00, 8'h00), fill(8'hFF, 8'hFF));
    do_skip("theta-69", 0, -69);
    do_update("sat mixed", 7'd8, 28'h0, 1, -5, fill(8'h7F, 8'h80), fill(8'h7F, 8'h80));
    do_update("sat max", 7'd10, 28'hFFFFFFF, 1, 3, fill(8'h7F, 8'h7F), fill(8'h7F, 8'h7F));
    do_update("sat min", 7'd11, 28'hFFFFFFF, 0, 3, fill(8'h80, 8'h80), fill(8'h80, 8'h80));
    do_update("alt hist", 7'd127, 28'h5555555, 0, 10, fill(8'h00, 8'h00), alt);

    drive(7'd1, 28'h0, 1, 100);
    step();
    drive(7'd2, 28'h0, 0, -100);
    chk("b2b first done", {done, done_updated, req_ready}, 3'b101);
    step();
    req_valid = 0;
    chk("b2b second done", {done, done_updated, mem_rd_en}, 3'b100);
    step();
    chk("b2b idle", done, 0);
    exp_skip += 2;

    mem_hold = 1;
    row = fill(8'h11, 8'h22);
    drive(7'd3, 28'h0, 1, -1);
    step();
    req_valid = 0;
    chk("abort rd_en", mem_rd_en, 1);
    step();
    rst = 1;
    step();
    chk("abort in reset", {req_ready, mem_rd_en, mem_wr_en, done}, 0);
    chk("abort wr_data cleared", mem_wr_data, 0);
    rst = 0;
    mem_hold = 0;
    exp_upd = 0;
    exp_skip = 0;
    #1;
    chk("abort ready after rst", req_ready, 1);
    inject = 1;
    step();
    inject = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stray rd_valid ignored", {mem_wr_en, done, req_ready}, 3'b001);
      step();
    end

    do_update("post reset", 7'd4, 28'h0, 0, 0, fill(8'h05, 8'h05), fill(8'h04, 8'h06));
    do_skip("post reset skip", 0, -90);
`ifdef PERCEPTRON_TRAINER_STATS_EN
    step();
    chk("stat_updates", stat_updates, exp_upd);
    chk("stat_skips", stat_skips, exp_skip);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Update stage directly downstream of branch resolution and upstream of the perceptron weight memory's write port.
- Accepts one resolved branch per request: the table index, a history snapshot, the actual outcome and the perceptron output y computed at predict time.
- Decides whether training is needed. If so, reads the weight row, applies saturating +/-1 updates and writes the row back.
- Holds at most one request in flight, which avoids read-modify-write hazards on the table.

Parameters:
- INDEX_BITS, 7, table index width (128 rows).
- HIST, 28, global history length; the row holds HIST+1 weights, w0 being the bias.
- W_BITS, 8, signed two's-complement width of each weight.
- THETA, 68, training threshold, floor(1.93*HIST+14).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  resolved-branch request
- req_ready  out  1  unit can accept a request
- req_idx  in  INDEX_BITS  row index
- req_hist  in  HIST  history snapshot; bit i is x(i+1), 1 = taken
- req_taken  in  1  actual outcome
- req_y  in  Y_BITS  signed perceptron output from predict time
- mem_rd_en  out  1  row read strobe
- mem_rd_idx  out  INDEX_BITS  read index
- mem_rd_valid  in  1  read data valid, one cycle after mem_rd_en
- mem_rd_data  in  (HIST+1)*W_BITS  packed row
- mem_wr_en  out  1  row write strobe
- mem_wr_idx  out  INDEX_BITS  write index
- mem_wr_data  out  (HIST+1)*W_BITS  updated packed row
- done  out  1  one-cycle pulse: request retired
- done_updated  out  1  qualifies done; 1 = row written, 0 = training skipped

Behaviour:
- Y_BITS = W_BITS + clog2(HIST+1) + 1.
- Row packing: weight i occupies bits [i*W_BITS +: W_BITS].
- Predicted taken iff req_y >= 0.
- Training is needed iff prediction != req_taken, or |req_y| <= THETA.
- Update rule, with t = +1 if taken and -1 otherwise:
  - w0 += t.
  - wi += (x(i) == t) ? +1 : -1, where x = +1 for a history bit of 1 and -1 for a 0.
  - Saturate to [-2^(W_BITS-1), 2^(W_BITS-1)-1]. Increment at max and decrement at min leave the weight unchanged.
- FSM states are IDLE, RD, WAIT, WR.
  - IDLE: req_ready=1. On req_valid, latch idx, hist, taken and the need flag.
    - Need flag set: go to RD.
    - Need flag clear: stay in IDLE, pulse done=1 with done_updated=0 the next cycle, and issue no memory access.
  - RD: mem_rd_en=1, mem_rd_idx=latched idx, for exactly one cycle. Go to WAIT.
  - WAIT: hold until mem_rd_valid. On rd_valid, compute all HIST+1 updated weights from mem_rd_data in parallel, register them into mem_wr_data, and go to WR.
  - WR: mem_wr_en=1 and mem_wr_idx=latched idx for one cycle, with done=1 and done_updated=1 in the same cycle. Go to IDLE.
- Latency for an update accepted at edge T:
  - mem_rd_en high in cycle T+1.
  - rd_valid in cycle T+2.
  - mem_wr_en and done in cycle T+3.
  - req_ready high again in cycle T+4.
- Latency for a skip accepted at T: done in T+1. Back-to-back skips are allowed every cycle.
- req_ready is low in RD, WAIT and WR, and low while rst is asserted.
- mem_rd_valid arriving outside WAIT is ignored.
- Reset: state returns to IDLE. mem_rd_en, mem_wr_en, done and done_updated go to 0. mem_wr_data, mem_wr_idx and mem_rd_idx go to 0.
- Reset mid-operation drops the in-flight request: no write is issued and no done pulse follows.
- mem_rd_en, mem_wr_en, done and mem_wr_data are registered. req_ready is decoded from state.

Optional Feature:
- Macro: PERCEPTRON_TRAINER_STATS_EN.
- When defined, adds outputs stat_updates and stat_skips, both 32 bits.
  - stat_updates increments on each done with done_updated=1.
  - stat_skips increments on each done with done_updated=0.
  - Both wrap at 2^32, clear on rst, and increment when done pulses.
- When not defined, neither port nor counter exists.

Decomposition:
- Package perceptron_pkg holds:
  - Y_BITS computation function.
  - Default THETA constant.
  - Weight min/max constants as functions of W_BITS.
  - Typedef for the FSM state enum.
  - Row slice/pack helper functions.
- One sub-module, perceptron_weight_sat: combinational single-weight +/-1 saturating adder, instantiated HIST+1 times via generate.

Test Plan:
- Mispredict: req_y=-5, taken=1, all weights 0, hist all 1 -> mem_wr_en in cycle T+3; written row is all +1; done_updated=1.
- Confident correct: req_y=100, taken=1 -> no mem_rd_en; done pulse in T+1 with done_updated=0; req_ready stays 1.
- Low-confidence correct at boundary: req_y=68, taken=1 -> update happens. req_y=69 -> skip.
- Saturation: row all +127 and all -128 (bias +127, weights -128), taken=1, hist=0 -> bias stays +127; history weights stay -128.
- Mixed history: hist alternating 1/0, weights 0, taken=0 -> weights at taken positions become -1, the others +1, bias becomes -1.
- Reset asserted during WAIT -> no mem_wr_en, no done; req_ready=1 on the first cycle after rst drops.
